// File: rtl/shift_rows_pkg.sv
// rtl/shift_rows_pkg.sv - register offsets, bit indices, FSM type and ShiftRows permutation
// Shared by shift_rows_core and shift_rows_axi (no ports).
// The inverse permutation is used only when SHIFT_ROWS_INV_EN is defined.
package shift_rows_pkg;

  // Byte offsets of the register map
  localparam logic [5:0] OFF_IN0    = 6'h00;
  localparam logic [5:0] OFF_IN3    = 6'h0C;
  localparam logic [5:0] OFF_OUT0   = 6'h10;
  localparam logic [5:0] OFF_OUT3   = 6'h1C;
  localparam logic [5:0] OFF_CTRL   = 6'h20;
  localparam logic [5:0] OFF_STATUS = 6'h24;

  localparam int CTRL_START  = 0;
  localparam int CTRL_INV    = 1;
  localparam int CTRL_IE     = 2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_ERR  = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sr_state_e;

  // Word c sits at state[32*c +: 32]; row r of that word is bits [31-8r -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] state, input logic inv);
    logic [127:0] res;
    int           src;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
        res[32*c + 24 - 8*r +: 8] = state[32*src + 24 - 8*r +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/shift_rows_core.sv
// rtl/shift_rows_core.sv - operand snapshot, latency counter and IDLE/BUSY sequencer
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               request; accepted only in IDLE
//   inv                 inverse-mode select (used only with SHIFT_ROWS_INV_EN)
//   state[127:0]        operand, snapshotted on accept
//   busy                high while an operation is in flight
//   done_pulse          one-cycle strobe on the cycle result is latched
//   result[127:0]       permuted state, held until the next completion
module shift_rows_core
  import shift_rows_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         inv,
  input  logic [127:0] state,
  output logic         busy,
  output logic         done_pulse,
  output logic [127:0] result
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  sr_state_e    cur_state;
  sr_state_e    next_state;
  logic [3:0]   cnt;
  logic [127:0] snap;
  logic         accept;
  logic         perm_inv;

  assign accept = (cur_state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= IDLE;
    end else begin
      cur_state <= next_state;
    end
  end

  always_comb begin
    next_state = cur_state;
    busy       = 1'b0;
    done_pulse = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start) next_state = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == 4'd0) begin
          done_pulse = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      snap   <= '0;
      result <= '0;
    end else begin
      if (accept) begin
        cnt  <= CNT_INIT;
        snap <= state;
      end else if (busy && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (done_pulse) begin
        result <= shift_rows(snap, perm_inv);
      end
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  logic snap_inv;

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_inv <= 1'b0;
    end else if (accept) begin
      snap_inv <= inv;
    end
  end

  assign perm_inv = snap_inv;
`else
  logic unused_inv;
  assign unused_inv = inv;
  assign perm_inv   = 1'b0;
`endif

endmodule

// File: rtl/shift_rows_axi.sv
// rtl/shift_rows_axi.sv - AXI4-Lite register file around the ShiftRows core
// Ports:
//   ACLK, ARESET        clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*     AXI4-Lite write address/data/response (AWPROT ignored)
//   S_AXI_AR*/R*        AXI4-Lite read address/data (ARPROT ignored)
//   irq                 level interrupt = STATUS.DONE & CTRL.IE
// Build option: SHIFT_ROWS_INV_EN implements CTRL.INV (inverse ShiftRows).
module shift_rows_axi
  import shift_rows_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_LATENCY          = 1
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            irq
);

  logic [3:0][31:0] in_reg;
  logic [127:0]     result;
  logic             ctrl_ie;
  logic             ctrl_inv;
  logic             st_done;
  logic             st_err;
  logic             aw_rdy;
  logic             b_vld;
  logic             ar_rdy;
  logic             r_vld;
  logic [31:0]      r_data;
  logic [31:0]      rd_word;
  logic [5:0]       wr_off;
  logic [5:0]       rd_off;
  logic             wr_en;
  logic             rd_en;
  logic             ctrl_wr;
  logic             status_wr;
  logic             start_req;
  logic             start_ok;
  logic             core_busy;
  logic             core_done;

  assign wr_off    = {S_AXI_AWADDR[5:2], 2'b00};
  assign rd_off    = {S_AXI_ARADDR[5:2], 2'b00};
  assign wr_en     = aw_rdy && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en     = ar_rdy && S_AXI_ARVALID;
  assign ctrl_wr   = wr_en && (wr_off == OFF_CTRL) && S_AXI_WSTRB[0];
  assign status_wr = wr_en && (wr_off == OFF_STATUS);
  assign start_req = ctrl_wr && S_AXI_WDATA[CTRL_START];
  // A START arriving while the core is busy (including its completion cycle) is refused.
  assign start_ok  = start_req && !core_busy;

  // Write channel: AWREADY/WREADY pulse together; no new accept while a response is pending.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_rdy <= 1'b0;
      b_vld  <= 1'b0;
    end else begin
      aw_rdy <= !aw_rdy && S_AXI_AWVALID && S_AXI_WVALID && !b_vld;
      if (wr_en) begin
        b_vld <= 1'b1;
      end else if (S_AXI_BREADY) begin
        b_vld <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      in_reg <= '0;
    end else if (wr_en && (wr_off[5:4] == OFF_IN0[5:4])) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) begin
          in_reg[wr_off[3:2]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_ie <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_ie <= S_AXI_WDATA[CTRL_IE];
    end
  end

`ifdef SHIFT_ROWS_INV_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ctrl_inv <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_inv <= S_AXI_WDATA[CTRL_INV];
    end
  end
`else
  assign ctrl_inv = 1'b0;
`endif

  // DONE: completion beats a same-cycle W1C; an accepted START clears it.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
    end else begin
      if (core_done) begin
        st_done <= 1'b1;
      end else if (start_ok || (status_wr && S_AXI_WDATA[STATUS_DONE])) begin
        st_done <= 1'b0;
      end
      if (start_req && core_busy) begin
        st_err <= 1'b1;
      end else if (status_wr && S_AXI_WDATA[STATUS_ERR]) begin
        st_err <= 1'b0;
      end
    end
  end

  shift_rows_core #(
    .LATENCY (C_LATENCY)
  ) u_core (
    .clk        (ACLK),
    .rst        (ARESET),
    .start      (start_ok),
    .inv        (ctrl_inv),
    .state      (in_reg),
    .busy       (core_busy),
    .done_pulse (core_done),
    .result     (result)
  );

  always_comb begin
    rd_word = '0;
    if (rd_off[5:4] == OFF_IN0[5:4]) begin
      rd_word = in_reg[rd_off[3:2]];
    end else if (rd_off[5:4] == OFF_OUT0[5:4]) begin
      rd_word = result[{rd_off[3:2], 5'd0} +: 32];
    end else if (rd_off == OFF_CTRL) begin
      rd_word[CTRL_INV] = ctrl_inv;
      rd_word[CTRL_IE]  = ctrl_ie;
    end else if (rd_off == OFF_STATUS) begin
      rd_word[STATUS_BUSY] = core_busy;
      rd_word[STATUS_DONE] = st_done;
      rd_word[STATUS_ERR]  = st_err;
    end
  end

  // Read channel: RDATA is captured once at the AR handshake and held until RREADY.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_data <= '0;
    end else begin
      ar_rdy <= !ar_rdy && S_AXI_ARVALID && !r_vld;
      if (rd_en) begin
        r_vld  <= 1'b1;
        r_data <= rd_word;
      end else if (S_AXI_RREADY) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign irq           = st_done && ctrl_ie;

  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

endmodule

// File: tb/tb_shift_rows_axi.sv
// tb/tb_shift_rows_axi.sv - scoreboard bench for shift_rows_axi
module tb_shift_rows_axi;

  localparam int LAT = 8;
  localparam logic [5:0] A_IN0 = 6'h00, A_IN1 = 6'h04, A_IN2 = 6'h08;
  localparam logic [5:0] A_OUT0 = 6'h10, A_CTRL = 6'h20, A_STATUS = 6'h24;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [5:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [5:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        irq;

  always #5 ACLK = ~ACLK;

  shift_rows_axi #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (6),
    .C_LATENCY          (LAT)
  ) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .S_AXI_AWADDR (S_AXI_AWADDR), .S_AXI_AWPROT (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID), .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA (S_AXI_WDATA), .S_AXI_WSTRB (S_AXI_WSTRB),
    .S_AXI_WVALID (S_AXI_WVALID), .S_AXI_WREADY (S_AXI_WREADY),
    .S_AXI_BRESP (S_AXI_BRESP), .S_AXI_BVALID (S_AXI_BVALID), .S_AXI_BREADY (S_AXI_BREADY),
    .S_AXI_ARADDR (S_AXI_ARADDR), .S_AXI_ARPROT (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID), .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA (S_AXI_RDATA), .S_AXI_RRESP (S_AXI_RRESP),
    .S_AXI_RVALID (S_AXI_RVALID), .S_AXI_RREADY (S_AXI_RREADY),
    .irq (irq)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          b_issued = 0, b_seen = 0, r_issued = 0, r_seen = 0;
  logic [31:0] r_exp_q[$];
  string       r_tag_q[$];
  string       mon_tag;
  logic [31:0] mon_exp;
  logic [31:0] r_hold;
  bit          r_first = 1'b0;
  bit          rand_en = 1'b0;

  logic [3:0][31:0] fips_in, fips_out, rin, cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][31:0] model_fwd(input logic [3:0][31:0] w);
    logic [3:0][31:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = w[(c + r) % 4][31-8*r -: 8];
    return o;
  endfunction

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb, input bit skew);
    bit ok = 1'b0;
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    if (skew) begin
      repeat (2) @(posedge ACLK);
      #1;
      check("aw_alone_no_ready", {31'd0, S_AXI_AWREADY}, 32'd0);
    end
    S_AXI_WVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (S_AXI_AWREADY) begin
        ok = 1'b1;
        break;
      end
    end
    check("aw_handshake", {31'd0, ok}, 32'd1);
    check("wready_with_awready", {31'd0, S_AXI_WREADY}, {31'd0, S_AXI_AWREADY});
    @(posedge ACLK);
    #1;
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    b_issued++;
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp, input string tag);
    bit ok = 1'b0;
    r_exp_q.push_back(exp);
    r_tag_q.push_back(tag);
    r_issued++;
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (S_AXI_ARREADY) begin
        ok = 1'b1;
        break;
      end
    end
    check("ar_handshake", {31'd0, ok}, 32'd1);
    @(posedge ACLK);
    #1;
    S_AXI_ARVALID = 1'b0;
  endtask

  task automatic drain();
    int i = 0;
    while ((r_exp_q.size() != 0 || b_seen != b_issued || S_AXI_RVALID || S_AXI_BVALID) && i < 300) begin
      @(negedge ACLK);
      i++;
    end
    check("drain_in_time", {31'd0, i < 300}, 32'd1);
    @(posedge ACLK);
    #1;
  endtask

  task automatic load_in(input logic [3:0][31:0] v);
    for (int i = 0; i < 4; i++) wr(6'(A_IN0 + 4*i), v[i], 4'hf, 1'b0);
  endtask

  task automatic read_out(input logic [3:0][31:0] v, input string tag);
    for (int i = 0; i < 4; i++) rd(6'(A_OUT0 + 4*i), v[i], $sformatf("%s_out%0d", tag, i));
  endtask

  // Ready driver: back-pressure only while rand_en is set
  initial begin
    forever begin
      @(posedge ACLK);
      #2;
      S_AXI_BREADY = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      S_AXI_RREADY = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Response monitor / scoreboard
  initial begin
    forever begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        b_seen++;
        check("bresp_okay", {30'd0, S_AXI_BRESP}, 32'd0);
      end
      if (S_AXI_RVALID) begin
        if (!r_first) begin
          r_hold  = S_AXI_RDATA;
          r_first = 1'b1;
        end
        if (S_AXI_RREADY) begin
          r_seen++;
          r_first = 1'b0;
          check("rdata_held", S_AXI_RDATA, r_hold);
          check("rresp_okay", {30'd0, S_AXI_RRESP}, 32'd0);
          check("r_expected_pending", {31'd0, r_exp_q.size() != 0}, 32'd1);
          if (r_exp_q.size() != 0) begin
            mon_exp = r_exp_q.pop_front();
            mon_tag = r_tag_q.pop_front();
            check(mon_tag, S_AXI_RDATA, mon_exp);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fips_in  = {32'h1e415230, 32'hb8b45de5, 32'he0bf98f1, 32'hd42711ae};
    fips_out = {32'h1e2798e5, 32'hb84111f1, 32'he0b452ae, 32'hd4bf5d30};

    // Reset
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
    check("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
    check("rst_arready", {31'd0, S_AXI_ARREADY}, 32'd0);
    check("rst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
    check("rst_rdata", S_AXI_RDATA, 32'd0);
    for (int i = 0; i < 12; i++) rd(6'(4*i), 32'd0, $sformatf("rst_reg%0d", i));
    wr(6'h3c, 32'hdeadbeef, 4'hf, 1'b0);
    rd(6'h3c, 32'd0, "unmapped_rd");
    drain();

    // Forward FIPS-197 round 1, IE set, irq latency
    load_in(fips_in);
    wr(A_CTRL, 32'h4, 4'hf, 1'b0);
    wr(A_CTRL, 32'h5, 4'hf, 1'b0);
    repeat (LAT - 1) @(posedge ACLK);
    @(negedge ACLK);
    check("irq_before_done", {31'd0, irq}, 32'd0);
    @(negedge ACLK);
    check("irq_at_done", {31'd0, irq}, 32'd1);
    drain();
    read_out(fips_out, "fwd");
    rd(A_STATUS, 32'h2, "fwd_status_done");
    rd(A_CTRL, 32'h4, "fwd_ctrl_start_reads0");
    rd(A_IN0, fips_in[0], "fwd_in0_readback");
    drain();

`ifdef SHIFT_ROWS_INV_EN
    // Inverse, started with DONE still set
    load_in(fips_out);
    wr(A_CTRL, 32'h3, 4'hf, 1'b0);
    rd(A_STATUS, 32'h1, "inv_status_busy");
    repeat (LAT + 3) @(posedge ACLK);
    drain();
    read_out(fips_in, "inv");
    rd(A_CTRL, 32'h2, "inv_ctrl");
    rd(A_STATUS, 32'h2, "inv_status_done");
    drain();
`else
    wr(A_CTRL, 32'h2, 4'hf, 1'b0);
    rd(A_CTRL, 32'h0, "noinv_ctrl");
    drain();
`endif

    // Random forward vector against the bench model, START with DONE=1
    for (int i = 0; i < 4; i++) rin[i] = $urandom;
    load_in(rin);
    wr(A_CTRL, 32'h1, 4'hf, 1'b0);
    rd(A_STATUS, 32'h1, "rnd_status_busy");
    repeat (LAT + 3) @(posedge ACLK);
    drain();
    read_out(model_fwd(rin), "rnd");
    drain();

    // Interrupt enable on a pending DONE, then W1C
    wr(A_CTRL, 32'h4, 4'hf, 1'b0);
    @(negedge ACLK);
    check("irq_ie_set", {31'd0, irq}, 32'd1);
    wr(A_STATUS, 32'h2, 4'hf, 1'b0);
    @(negedge ACLK);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd(A_STATUS, 32'h0, "status_after_w1c");
    drain();

    // Busy collision
    load_in(fips_in);
    wr(A_CTRL, 32'h1, 4'hf, 1'b0);
    wr(A_CTRL, 32'h1, 4'hf, 1'b0);
    wr(A_IN0, 32'hffffffff, 4'hf, 1'b0);
    repeat (LAT + 3) @(posedge ACLK);
    drain();
    rd(A_STATUS, 32'h6, "coll_status_err");
    read_out(fips_out, "coll");
    rd(A_IN0, 32'hffffffff, "coll_in0");
    wr(A_STATUS, 32'h4, 4'hf, 1'b0);
    rd(A_STATUS, 32'h2, "coll_err_cleared");
    drain();

    // Handshake stress with back-pressure and skew
    rand_en = 1'b1;
    wr(A_IN2, 32'h11223344, 4'hf, 1'b0);
    wr(A_IN2, 32'haabbccdd, 4'h3, 1'b1);
    rd(A_IN2, 32'h1122ccdd, "strb_in2");
    cur[0] = 32'h1122ccdd;
    for (int k = 0; k < 8; k++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      for (int b = 0; b < 4; b++)
        if (s[b]) cur[0][8*b +: 8] = d[8*b +: 8];
      wr(A_IN2, d, s, 1'($urandom_range(0, 1)));
      rd(A_IN2, cur[0], $sformatf("stress_in2_%0d", k));
    end
    wr(A_OUT0, 32'h0badf00d, 4'hf, 1'b1);
    rd(A_OUT0, fips_out[0], "out_write_dropped");
    drain();
    rand_en = 1'b0;
    drain();

    // Reset in the middle of an operation
    wr(A_CTRL, 32'h5, 4'hf, 1'b0);
    drain();
    ARESET = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    check("midrst_rvalid", {31'd0, S_AXI_RVALID}, 32'd0);
    read_out('0, "midrst");
    rd(A_STATUS, 32'h0, "midrst_status");
    rd(A_IN0, 32'h0, "midrst_in0");
    rd(A_CTRL, 32'h0, "midrst_ctrl");
    drain();

    check("b_count", 32'(b_seen), 32'(b_issued));
    check("r_count", 32'(r_seen), 32'(r_issued));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
